dist_ram_sdp: RTL
=================

// Module: dist_ram_sdp
// PURPOSE
//  Parametrised simple-dual-port distributed RAM: one write port with byte enables, one read port with a registered output.
//  Output register has clock-enable and synchronous clear.
//  After reset, a built-in clear sequencer zeroes every word; user traffic is held off until the sweep is done.
//  Used for register files, scratch buffers and small lookup tables in the RVP datapath.
// PARAMETERS
//  WIDTH        32  data width in bits; must be a multiple of 8
//  DEPTH        32  number of words; need not be a power of 2
//  ADDR_W        6  address width; must satisfy 2**ADDR_W >= DEPTH
//  WRITE_FIRST   1  1: same-address read returns the new data; 0: returns the old data
//  CLEAR_ON_RST  1  1: run the clear sweep after reset; 0: skip it, contents undefined
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous, active-low reset
//  init_busy  out  1          1 while the clear sweep runs
//  we         in   1          write strobe
//  wa         in   ADDR_W     write address
//  wd         in   WIDTH      write data
//  wbe        in   WIDTH/8    byte-lane write enables
//  ra         in   ADDR_W     read address
//  q_ce       in   1          output register enable
//  q_srst     in   1          synchronous clear of the output register
//  q          out  WIDTH      registered read data
//  q_perr     out  1          parity error flag; port exists only with DIST_RAM_PARITY_EN
// BEHAVIOUR
//  Reset (rst_n=0): q=0, q_perr=0, sweep counter=0.
//   - CLEAR_ON_RST=1: init_busy=1, FSM=CLEAR.
//   - CLEAR_ON_RST=0: init_busy=0, FSM=READY.
//  FSM CLEAR:
//   - Writes 0 to word cnt each cycle; cnt increments.
//   - At cnt==DEPTH-1: go to READY and drop init_busy the next cycle. Sweep takes DEPTH cycles.
//   - we and q_ce are ignored; q holds 0.
//  FSM READY: stays until reset. rst_n asserted mid-sweep restarts the sweep from word 0.
//  Write (READY, we=1, wa<DEPTH):
//   - Each lane i with wbe[i]=1 takes wd[8i+7:8i] at the clock edge.
//   - Lanes with wbe[i]=0 keep their contents.
//   - wa>=DEPTH: the write is dropped silently.
//  Read: 1-cycle latency. Priority per edge:
//   - q_srst=1          -> q=0 (overrides q_ce)
//   - else q_ce=1       -> q=mem[ra]
//   - else              -> q holds
//   - ra>=DEPTH         -> reads as 0
//  Collision (we=1, wa==ra, q_ce=1, same edge):
//   - WRITE_FIRST=1: q = merge(old, wd, wbe), byte by byte.
//   - WRITE_FIRST=0: q = old word.
//   - Memory is updated in both cases.
//  Memory array is asynchronous-read distributed storage; only q is registered.
// CONFIGURATION
//  DIST_RAM_PARITY_EN defined:
//   - One even-parity bit per byte is stored alongside the data; the clear sweep writes parity 0.
//   - On a read, q_perr = OR of per-byte parity mismatches, registered with q and obeying the same q_srst/q_ce rules.
//   - Collision forwarding regenerates parity from the merged data.
//  DIST_RAM_PARITY_EN undefined: no parity storage, no q_perr port.
// STRUCTURE
//  Package dist_ram_pkg:
//   - FSM state typedef {CLEAR, READY}
//   - BYTE_W=8 constant
//   - functions byte_merge(old,new,be) and byte_parity(data)
//  Sub-module dist_ram_clear_ctrl: FSM, sweep counter, init_busy, and the muxing of internal/external write controls.
//  Storage, write logic and the output register stay in dist_ram_sdp.
// TESTING
//  1. Release rst_n, DEPTH=32 -> init_busy high exactly 32 cycles; then every ra reads 0 one cycle after q_ce.
//  2. wa=5, wd=32'hA1B2C3D4, wbe=4'b0101 over 32'hFFFFFFFF -> ra=5 reads 32'hFFB2FFD4.
//  3. Collision wa=ra=7 (old 0, wd=32'h12345678, wbe=4'hF) -> q=32'h12345678 (WRITE_FIRST=1) or 0 (WRITE_FIRST=0).
//  4. q_srst=1 and q_ce=1 on the same edge -> q=0; q_ce=0 -> q holds its previous value.
//  5. DEPTH=24: write wa=30 is dropped, ra=30 reads 0; pulse rst_n low at sweep cycle 10 -> sweep restarts, 24 cycles.
//  6. With DIST_RAM_PARITY_EN: force one stored parity bit flipped at addr 3 -> q_perr=1 on its read; reads of other addresses give q_perr=0.

Source files
------------

// File: rtl/dist_ram_pkg.sv
// Shared definitions for the dist_ram_sdp simple-dual-port distributed RAM:
// FSM state type, byte-lane constants and byte-lane helper functions.
// The helpers work on a fixed maximum width. Callers zero-extend their
// operands and truncate the result with size casts.
package dist_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } ram_state_t;

  localparam int BYTE_W    = 8;
  localparam int MAX_W     = 1024;
  localparam int MAX_LANES = MAX_W / BYTE_W;

  // Byte-wise merge: each lane with be[i]=1 takes new_data, others keep old_data
  function automatic logic [MAX_W-1:0] byte_merge(
    input logic [MAX_W-1:0]     old_data,
    input logic [MAX_W-1:0]     new_data,
    input logic [MAX_LANES-1:0] be
  );
    logic [MAX_W-1:0] res;
    res = old_data;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (be[i]) res[i*BYTE_W +: BYTE_W] = new_data[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

  // Even parity per byte lane (bit i = XOR of lane i)
  function automatic logic [MAX_LANES-1:0] byte_parity(
    input logic [MAX_W-1:0] data
  );
    logic [MAX_LANES-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      p[i] = ^data[i*BYTE_W +: BYTE_W];
    end
    return p;
  endfunction

endpackage

// File: rtl/dist_ram_clear_ctrl.sv
// Post-reset clear sequencer for dist_ram_sdp. While the FSM is in CLEAR it
// owns the RAM write port and writes zero to one word per cycle. In READY it
// passes the user write through, and it drops writes whose address is out of
// range.
module dist_ram_clear_ctrl #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 32,
  parameter int ADDR_W       = 6,
  parameter int IDX_W        = 5,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic [WIDTH/8-1:0]   wbe,
  output logic                 init_busy,
  output logic                 ready,
  output logic                 mem_we,
  output logic [IDX_W-1:0]     mem_wa,
  output logic [WIDTH-1:0]     mem_wd,
  output logic [WIDTH/8-1:0]   mem_wbe
);
  import dist_ram_pkg::*;

  localparam ram_state_t       RST_STATE = (CLEAR_ON_RST != 0) ? CLEAR : READY;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);

  ram_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  // State and sweep counter registers; reset restarts the sweep from word 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, sweep advance and write-port mux between the sweep and the user
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    init_busy = 1'b0;
    ready     = 1'b0;
    mem_we    = 1'b0;
    mem_wa    = wa[IDX_W-1:0];
    mem_wd    = wd;
    mem_wbe   = wbe;
    case (state)
      CLEAR: begin
        init_busy = 1'b1;
        mem_we    = 1'b1;
        mem_wa    = cnt[IDX_W-1:0];
        mem_wd    = '0;
        mem_wbe   = '1;
        if (cnt == LAST_IDX) begin
          state_nxt = READY;
        end else begin
          cnt_nxt = cnt + ADDR_W'(1);
        end
      end
      READY: begin
        ready  = 1'b1;
        mem_we = we && ({1'b0, wa} < DEPTH_X);
      end
      default: begin
        state_nxt = RST_STATE;
      end
    endcase
  end

endmodule

// File: rtl/dist_ram_sdp.sv
// Simple-dual-port distributed RAM. It has one write port with byte enables
// and one asynchronous read path into a registered output. The output
// register has its own clock enable and synchronous clear. After reset a
// clear sweep zeroes every word.
// Optional feature: define DIST_RAM_PARITY_EN to store one even-parity bit per
// byte. This adds the registered q_perr error flag.
module dist_ram_sdp #(
  parameter int WIDTH        = 32,
  parameter int DEPTH        = 32,
  parameter int ADDR_W       = 6,
  parameter int WRITE_FIRST  = 1,
  parameter int CLEAR_ON_RST = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 init_busy,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    wa,
  input  logic [WIDTH-1:0]     wd,
  input  logic [WIDTH/8-1:0]   wbe,
  input  logic [ADDR_W-1:0]    ra,
  input  logic                 q_ce,
  input  logic                 q_srst,
  output logic [WIDTH-1:0]     q
`ifdef DIST_RAM_PARITY_EN
  ,
  output logic                 q_perr
`endif
);
  import dist_ram_pkg::*;

  localparam int              LANES   = WIDTH / BYTE_W;
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic             ready;
  logic             mem_we;
  logic [IDX_W-1:0] mem_wa;
  logic [WIDTH-1:0] mem_wd;
  logic [LANES-1:0] mem_wbe;

  dist_ram_clear_ctrl #(
    .WIDTH        (WIDTH),
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .IDX_W        (IDX_W),
    .CLEAR_ON_RST (CLEAR_ON_RST)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .wbe       (wbe),
    .init_busy (init_busy),
    .ready     (ready),
    .mem_we    (mem_we),
    .mem_wa    (mem_wa),
    .mem_wd    (mem_wd),
    .mem_wbe   (mem_wbe)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  logic             ra_ok;
  logic             fwd;
  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] rd_data;

  // Byte-lane writes into the storage array (no reset: distributed RAM)
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_wbe[i]) mem[mem_wa][i*BYTE_W +: BYTE_W] <= mem_wd[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Asynchronous read. Out-of-range addresses read as zero. Same-address
  // writes are forwarded when write-first.
  always_comb begin
    ra_ok    = ({1'b0, ra} < DEPTH_X);
    old_word = '0;
    if (ra_ok) old_word = mem[ra[IDX_W-1:0]];
    fwd     = (WRITE_FIRST != 0) && ready && we && (wa == ra) && ra_ok;
    rd_data = old_word;
    if (fwd) rd_data = WIDTH'(byte_merge(MAX_W'(old_word), MAX_W'(wd), MAX_LANES'(wbe)));
  end

`ifdef DIST_RAM_PARITY_EN
  logic [LANES-1:0] par [DEPTH];
  logic [LANES-1:0] old_par;
  logic [LANES-1:0] rd_par;
  logic             rd_perr;

  // Parity lanes are written together with their data lanes
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_wbe[i]) par[mem_wa][i] <= ^mem_wd[i*BYTE_W +: BYTE_W];
      end
    end
  end

  // Parity check. Forwarded lanes get parity regenerated from the new data.
  always_comb begin
    old_par = '0;
    if (ra_ok) old_par = par[ra[IDX_W-1:0]];
    rd_par = old_par;
    if (fwd) begin
      for (int i = 0; i < LANES; i++) begin
        if (wbe[i]) rd_par[i] = ^wd[i*BYTE_W +: BYTE_W];
      end
    end
    rd_perr = |(LANES'(byte_parity(MAX_W'(rd_data))) ^ rd_par);
  end

  // Error flag register follows the same clear/enable rules as q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_perr <= 1'b0;
    end else if (!ready || q_srst) begin
      q_perr <= 1'b0;
    end else if (q_ce) begin
      q_perr <= rd_perr;
    end
  end
`endif

  // Output register. It is held at zero during the sweep, the clear wins over
  // the enable, and otherwise it holds its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (!ready || q_srst) begin
      q <= '0;
    end else if (q_ce) begin
      q <= rd_data;
    end
  end

endmodule
